fan_proximity_ctrl: RTL and testbench

FAN_PROXIMITY_CTRL -- requirements
Module: fan_proximity_ctrl

---
 rtl/fan_proximity_ctrl.sv | 154 +++++++++++++++
 tb/tb_fan_proximity_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fan_proximity_ctrl.sv
// Proximity-triggered fan controller: samples an ultrasonic distance once per ms tick,
// confirms presence, runs the fan with a distance-dependent PWM duty and holds before stopping.
module fan_proximity_ctrl #(
  parameter int unsigned CLK_PER_MS = 100_000,
  parameter int unsigned NEAR_CM    = 30,
  parameter int unsigned FAR_CM     = 40,
  parameter int unsigned CONFIRM_MS = 200,
  parameter int unsigned HOLD_MS    = 3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] distance_cm,
  output logic        fan_en,
  output logic        pwm_out,
  output logic [8:0]  duty,
  output logic [1:0]  state
);

  localparam int unsigned TickW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int unsigned ConfW = (CONFIRM_MS > 1) ? $clog2(CONFIRM_MS + 1) : 1;
  localparam int unsigned HoldW = (HOLD_MS > 1) ? $clog2(HOLD_MS + 1) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(CLK_PER_MS - 1);
  localparam logic [ConfW-1:0] ConfLast = ConfW'((CONFIRM_MS > 1) ? CONFIRM_MS - 1 : 0);
  // The RUN->HOLD tick is the first far tick of the hold window, so HOLD exits on the
  // HOLD_MS-th consecutive far tick counted from leaving RUN.
  localparam logic [HoldW-1:0] HoldLast = HoldW'((HOLD_MS > 1) ? HOLD_MS - 2 : 0);

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2,
    StHold  = 2'd3
  } state_e;

  state_e             state_q;
  logic [TickW-1:0]   tick_cnt_q;
  logic [ConfW-1:0]   confirm_q;
  logic [HoldW-1:0]   hold_cnt_q;
  logic [7:0]         pwm_cnt_q;
  logic [8:0]         target_q;
  logic [8:0]         duty_q;
  logic               fan_en_q;

  logic               tick;
  logic               near;
  logic               far;
  logic [8:0]         band_duty;

  assign tick = (tick_cnt_q == TickLast);
  assign near = (distance_cm != 16'd0) && (distance_cm < 16'(NEAR_CM));
  assign far  = (distance_cm == 16'd0) || (distance_cm >= 16'(FAR_CM));

  always_comb begin
    band_duty = 9'd128;
    if (distance_cm < 16'd10) begin
      band_duty = 9'd256;
    end else if (distance_cm < 16'd20) begin
      band_duty = 9'd192;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StOff;
      tick_cnt_q <= '0;
      confirm_q  <= '0;
      hold_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      target_q   <= '0;
      duty_q     <= '0;
      fan_en_q   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      // Duty only changes at the period boundary; a later OFF entry below overrides this.
      if (pwm_cnt_q == 8'hff) begin
        duty_q <= target_q;
      end

      if (tick) begin
        tick_cnt_q <= '0;
        unique case (state_q)
          StOff: begin
            if (near) begin
              if (CONFIRM_MS <= 1) begin
                state_q  <= StRun;
                fan_en_q <= 1'b1;
                target_q <= band_duty;
              end else begin
                state_q   <= StArmed;
                confirm_q <= ConfW'(1);
              end
            end
          end
          StArmed: begin
            if (near) begin
              if (confirm_q >= ConfLast) begin
                state_q   <= StRun;
                confirm_q <= '0;
                fan_en_q  <= 1'b1;
                target_q  <= band_duty;
              end else begin
                confirm_q <= confirm_q + ConfW'(1);
              end
            end else if (far) begin
              state_q   <= StOff;
              confirm_q <= '0;
            end
          end
          StRun: begin
            if (near) begin
              target_q <= band_duty;
            end else if (far) begin
              if (HOLD_MS <= 1) begin
                state_q  <= StOff;
                fan_en_q <= 1'b0;
                target_q <= '0;
                duty_q   <= '0;
              end else begin
                state_q    <= StHold;
                hold_cnt_q <= '0;
              end
            end
          end
          StHold: begin
            if (near) begin
              state_q    <= StRun;
              hold_cnt_q <= '0;
              target_q   <= band_duty;
            end else if (far) begin
              if (hold_cnt_q >= HoldLast) begin
                state_q    <= StOff;
                hold_cnt_q <= '0;
                fan_en_q   <= 1'b0;
                target_q   <= '0;
                duty_q     <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + HoldW'(1);
              end
            end
          end
        endcase
      end else begin
        tick_cnt_q <= tick_cnt_q + TickW'(1);
      end
    end
  end

  assign fan_en  = fan_en_q;
  assign duty    = duty_q;
  assign state   = state_q;
  assign pwm_out = fan_en_q && ({1'b0, pwm_cnt_q} < duty_q);

endmodule

// File: tb/tb_fan_proximity_ctrl.sv
// Scoreboard bench for fan_proximity_ctrl: expected state/fan_en pushed per driven tick,
// popped after the tick edge; duty and PWM checked around period boundaries.
module tb_fan_proximity_ctrl;

  localparam int unsigned ClkPerMs = 10;

  logic        clk;
  logic        reset_n;
  logic [15:0] distance;
  logic        fan_en;
  logic        pwm_out;
  logic [8:0]  duty;
  logic [1:0]  state;

  int          cyc;
  int          n_cmp;
  int          n_err;
  logic [2:0]  exp_q[$];
  string       tag_q[$];

  fan_proximity_ctrl #(
    .CLK_PER_MS (ClkPerMs),
    .NEAR_CM    (30),
    .FAR_CM     (40),
    .CONFIRM_MS (3),
    .HOLD_MS    (5)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .distance_cm (distance),
    .fan_en      (fan_en),
    .pwm_out     (pwm_out),
    .duty        (duty),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; equals the DUT's free-running PWM phase modulo 256.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_pop();
    logic [2:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq({t, "/state"}, 32'(state), 32'(e[2:1]));
      check_eq({t, "/fan_en"}, 32'(fan_en), 32'(e[0]));
    end
  endtask

  // Drive a distance, queue the expected post-tick result, advance to the next tick edge.
  task automatic drive_tick(input logic [15:0] d, input logic [1:0] st, input logic fan,
                            input string tag);
    distance = d;
    exp_q.push_back({st, fan});
    tag_q.push_back(tag);
    do begin
      @(posedge clk); #1;
    end while (cyc % ClkPerMs != 0);
    sb_pop();
  endtask

  task automatic wait_boundary(input string tag, input logic [8:0] pre, input logic [8:0] post);
    do begin
      @(posedge clk); #1;
    end while (cyc % 256 != 255);
    check_eq({tag, "/pre"}, 32'(duty), 32'(pre));
    @(posedge clk); #1;
    check_eq({tag, "/post"}, 32'(duty), 32'(post));
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "/state"}, 32'(state), 32'd0);
    check_eq({tag, "/fan_en"}, 32'(fan_en), 32'd0);
    check_eq({tag, "/pwm_out"}, 32'(pwm_out), 32'd0);
    check_eq({tag, "/duty"}, 32'(duty), 32'd0);
  endtask

  localparam logic [15:0] BndDist[5] = '{16'd9, 16'd10, 16'd19, 16'd20, 16'd29};
  localparam logic [8:0]  BndDuty[5] = '{9'd256, 9'd192, 9'd192, 9'd128, 9'd128};

  initial begin
    int         hi;
    logic [8:0] prev;
    n_cmp    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    distance = 16'd15;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset_n = 1'b1;

    // Start sequence; first tick lands CLK_PER_MS cycles after release.
    repeat (9) @(posedge clk);
    #1;
    check_eq("first_tick_early", 32'(state), 32'd0);
    drive_tick(16'd15, 2'd1, 1'b0, "start_t1");
    drive_tick(16'd15, 2'd1, 1'b0, "start_t2");
    drive_tick(16'd15, 2'd2, 1'b1, "start_t3");
    check_eq("start_duty_pending", 32'(duty), 32'd0);
    wait_boundary("start_duty", 9'd0, 9'd192);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      hi += int'(pwm_out);
    end
    check_eq("pwm_192_count", 32'(hi), 32'd192);

    // Hysteresis band leaves RUN and duty untouched.
    for (int i = 0; i < 20; i++) drive_tick(16'd35, 2'd2, 1'b1, "band");
    check_eq("band_duty", 32'(duty), 32'd192);

    // Hold then return, then hold to OFF.
    for (int i = 0; i < 4; i++) drive_tick(16'd50, 2'd3, 1'b1, "hold_a");
    drive_tick(16'd5, 2'd2, 1'b1, "hold_return");
    wait_boundary("hold_duty", 9'd192, 9'd256);
    for (int i = 0; i < 4; i++) drive_tick(16'd50, 2'd3, 1'b1, "hold_b");
    check_eq("hold_pwm_high", 32'(pwm_out), 32'd1);
    drive_tick(16'd50, 2'd0, 1'b0, "hold_off");
    check_quiet("hold_off");

    // Abort during arming.
    drive_tick(16'd15, 2'd1, 1'b0, "abort_t1");
    drive_tick(16'd15, 2'd1, 1'b0, "abort_t2");
    drive_tick(16'd0, 2'd0, 1'b0, "abort_far");
    check_quiet("abort");

    // Reset mid-operation while in HOLD with pwm_out high.
    drive_tick(16'd5, 2'd1, 1'b0, "rst_t1");
    drive_tick(16'd5, 2'd1, 1'b0, "rst_t2");
    drive_tick(16'd5, 2'd2, 1'b1, "rst_t3");
    wait_boundary("rst_duty", 9'd0, 9'd256);
    drive_tick(16'd50, 2'd3, 1'b1, "rst_hold");
    check_eq("rst_pwm_before", 32'(pwm_out), 32'd1);
    reset_n = 1'b0;
    #1;
    check_quiet("rst_async");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive_tick(16'd5, 2'd1, 1'b0, "rearm_t1");
    drive_tick(16'd5, 2'd1, 1'b0, "rearm_t2");
    drive_tick(16'd5, 2'd2, 1'b1, "rearm_t3");

    // Duty band edges; each new value appears only after a period boundary.
    prev = 9'd0;
    for (int i = 0; i < 5; i++) begin
      drive_tick(BndDist[i], 2'd2, 1'b1, $sformatf("bnd_d%0d", BndDist[i]));
      wait_boundary($sformatf("bnd_duty_d%0d", BndDist[i]), prev, BndDuty[i]);
      prev = BndDuty[i];
    end

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
